// File: rtl/i2c_target.sv
// i2c_target: I2C target with fixed 7-bit address, ACKed writes and served reads; optional glitch filter via I2C_TARGET_GLITCH_FILTER_EN
module i2c_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_next,
  output logic       rw,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP} state_t;
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_s, sda_s, scl_prev_q, sda_prev_q;
  logic       scl_rise, scl_fall, start_c, stop_c;
  state_t     state_q;
  logic [2:0] cnt_q;
  logic [7:0] sr_q, rx_data_q;
  logic       done_q, sda_oe_q, rx_valid_q, tx_next_q, rw_q, busy_q;
  // two-flop synchronisers on the asynchronous pads, idle-high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] scl_cnt_q, sda_cnt_q;
  logic          scl_f_q, sda_f_q;
  // filtered level follows the synced input only after FILTER_LEN equal samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
      scl_f_q   <= 1'b1;
      sda_f_q   <= 1'b1;
    end else begin
      if (scl_sync_q[1] == scl_f_q) scl_cnt_q <= '0;
      else if (scl_cnt_q == CW'(FILTER_LEN - 1)) begin
        scl_f_q   <= scl_sync_q[1];
        scl_cnt_q <= '0;
      end else scl_cnt_q <= scl_cnt_q + 1'b1;
      if (sda_sync_q[1] == sda_f_q) sda_cnt_q <= '0;
      else if (sda_cnt_q == CW'(FILTER_LEN - 1)) begin
        sda_f_q   <= sda_sync_q[1];
        sda_cnt_q <= '0;
      end else sda_cnt_q <= sda_cnt_q + 1'b1;
    end
  assign scl_s = scl_f_q;
  assign sda_s = sda_f_q;
`else
  logic unused_filter_len;
  assign unused_filter_len = (FILTER_LEN != 0);
  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
`endif
  // delayed copy of the conditioned lines for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start_c  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_c   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  // protocol FSM: bits sampled on SCL rise, SDA driven only after SCL fall
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      done_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_next_q  <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_next_q  <= 1'b0;
      if (start_c || stop_c) begin
        state_q  <= start_c ? ADDR : IDLE;
        cnt_q    <= '0;
        done_q   <= 1'b0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ADDR:
            if (scl_rise) begin
              sr_q   <= {sr_q[6:0], sda_s};
              cnt_q  <= cnt_q + 3'd1;
              done_q <= (cnt_q == 3'd7);
            end else if (scl_fall && done_q) begin
              done_q <= 1'b0;
              if (sr_q[7:1] == SLAVE_ADDR) begin
                state_q  <= ADDR_ACK;
                sda_oe_q <= 1'b1;
                rw_q     <= sr_q[0];
                busy_q   <= 1'b1;
              end else state_q <= WAIT_STOP;
            end
          ADDR_ACK:
            if (scl_fall) begin
              cnt_q <= '0;
              if (rw_q) begin
                sr_q      <= tx_data;
                tx_next_q <= 1'b1;
                sda_oe_q  <= ~tx_data[7];
                state_q   <= TX;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= RX;
              end
            end
          RX:
            if (scl_rise) begin
              sr_q  <= {sr_q[6:0], sda_s};
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                rx_data_q  <= {sr_q[6:0], sda_s};
                rx_valid_q <= 1'b1;
                done_q     <= 1'b1;
              end
            end else if (scl_fall && done_q) begin
              done_q   <= 1'b0;
              sda_oe_q <= 1'b1;
              state_q  <= RX_ACK;
            end
          RX_ACK:
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              cnt_q    <= '0;
              state_q  <= RX;
            end
          TX:
            if (scl_fall) begin
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                sda_oe_q <= 1'b0;
                state_q  <= TX_ACK;
              end else begin
                sda_oe_q <= ~sr_q[6];
                sr_q     <= {sr_q[6:0], 1'b0};
              end
            end
          TX_ACK:
            if (scl_rise && sda_s) begin
              state_q <= WAIT_STOP;
              busy_q  <= 1'b0;
            end else if (scl_fall) begin
              sr_q      <= tx_data;
              tx_next_q <= 1'b1;
              sda_oe_q  <= ~tx_data[7];
              cnt_q     <= '0;
              state_q   <= TX;
            end
          IDLE, WAIT_STOP: sda_oe_q <= 1'b0;
          default: state_q <= IDLE;
        endcase
      end
    end
  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_next  = tx_next_q;
  assign rw       = rw_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed I2C master bus model checking writes, reads, address mismatch, repeated START, reset and glitches
module tb_i2c_target;
  localparam int Q = 25;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_bus, sda_oe, rx_valid, tx_next, rw, busy;
  logic [7:0] rx_data;
  int errors = 0;
  int checks = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int oe_cnt = 0;
  assign sda_bus = sda_m & ~sda_oe;
  i2c_target dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_next(tx_next),
    .rw(rw), .busy(busy)
  );
  always #10 clk = ~clk;
  always @(negedge clk) begin
    rx_cnt <= rx_cnt + (rx_valid ? 1 : 0);
    tx_cnt <= tx_cnt + (tx_next ? 1 : 0);
    oe_cnt <= oe_cnt + (sda_oe ? 1 : 0);
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask
  task automatic bit_cycle(input logic b, output logic s);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(Q);
    s = sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask
  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
    bit_cycle(1'b1, ack);
  endtask
  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, s);
      d = {d[6:0], s};
    end
    bit_cycle(ack, s);
  endtask
  task automatic test_reset();
    rst_n = 1'b0; tick(4);
    @(negedge clk);
    checks += 6;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    if (tx_next !== 1'b0) begin errors++; $display("FAIL reset_tx_next got=%b exp=0", tx_next); end
    if (rw !== 1'b0) begin errors++; $display("FAIL reset_rw got=%b exp=0", rw); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1; tick(5);
  endtask
  task automatic test_write();
    logic a0, a1;
    int rx0;
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'h84, a0);
    checks += 3;
    if (a0 !== 1'b0) begin errors++; $display("FAIL write_addr_ack got=%b exp=0", a0); end
    if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got=%b exp=1", busy); end
    if (rw !== 1'b0) begin errors++; $display("FAIL write_rw got=%b exp=0", rw); end
    write_byte(8'hA5, a1);
    checks += 3;
    if (a1 !== 1'b0) begin errors++; $display("FAIL write_data_ack got=%b exp=0", a1); end
    if (rx_data !== 8'hA5) begin errors++; $display("FAIL write_rx_data got=%h exp=a5", rx_data); end
    if (rx_cnt - rx0 !== 1) begin errors++; $display("FAIL write_rx_valid_count got=%0d exp=1", rx_cnt - rx0); end
    i2c_stop();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop got=%b exp=0", busy); end
  endtask
  task automatic test_wrong_addr();
    logic a0, a1;
    int rx0, oe0;
    rx0 = rx_cnt; oe0 = oe_cnt;
    i2c_start();
    write_byte(8'h86, a0);
    write_byte(8'h11, a1);
    i2c_stop();
    tick(4);
    checks += 5;
    if (a0 !== 1'b1) begin errors++; $display("FAIL wrong_addr_nack got=%b exp=1", a0); end
    if (a1 !== 1'b1) begin errors++; $display("FAIL wrong_data_nack got=%b exp=1", a1); end
    if (oe_cnt - oe0 !== 0) begin errors++; $display("FAIL wrong_sda_oe_cycles got=%0d exp=0", oe_cnt - oe0); end
    if (rx_cnt - rx0 !== 0) begin errors++; $display("FAIL wrong_rx_valid_count got=%0d exp=0", rx_cnt - rx0); end
    if (busy !== 1'b0) begin errors++; $display("FAIL wrong_busy got=%b exp=0", busy); end
  endtask
  task automatic test_read();
    logic a0;
    logic [7:0] d0, d1;
    int tx0;
    tx0 = tx_cnt;
    tx_data = 8'h3C;
    i2c_start();
    write_byte(8'h85, a0);
    checks += 4;
    if (a0 !== 1'b0) begin errors++; $display("FAIL read_addr_ack got=%b exp=0", a0); end
    if (rw !== 1'b1) begin errors++; $display("FAIL read_rw got=%b exp=1", rw); end
    if (busy !== 1'b1) begin errors++; $display("FAIL read_busy got=%b exp=1", busy); end
    if (tx_cnt - tx0 !== 1) begin errors++; $display("FAIL read_tx_next_first got=%0d exp=1", tx_cnt - tx0); end
    tx_data = 8'hC3;
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    checks += 4;
    if (d0 !== 8'h3C) begin errors++; $display("FAIL read_byte1 got=%h exp=3c", d0); end
    if (d1 !== 8'hC3) begin errors++; $display("FAIL read_byte2 got=%h exp=c3", d1); end
    if (tx_cnt - tx0 !== 2) begin errors++; $display("FAIL read_tx_next_count got=%0d exp=2", tx_cnt - tx0); end
    if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after_nack got=%b exp=0", busy); end
    i2c_stop();
  endtask
  task automatic test_repeated_start();
    logic a0, a1, s;
    logic [7:0] d;
    int rx0;
    rx0 = rx_cnt;
    tx_data = 8'h5A;
    i2c_start();
    write_byte(8'h84, a0);
    bit_cycle(1'b1, s); bit_cycle(1'b0, s); bit_cycle(1'b1, s); bit_cycle(1'b0, s);
    i2c_start();
    write_byte(8'h85, a1);
    read_byte(1'b1, d);
    i2c_stop();
    checks += 5;
    if (a0 !== 1'b0) begin errors++; $display("FAIL rs_first_ack got=%b exp=0", a0); end
    if (a1 !== 1'b0) begin errors++; $display("FAIL rs_readdr_ack got=%b exp=0", a1); end
    if (rw !== 1'b1) begin errors++; $display("FAIL rs_rw got=%b exp=1", rw); end
    if (d !== 8'h5A) begin errors++; $display("FAIL rs_read_byte got=%h exp=5a", d); end
    if (rx_cnt - rx0 !== 0) begin errors++; $display("FAIL rs_rx_valid_count got=%0d exp=0", rx_cnt - rx0); end
  endtask
  task automatic test_reset_mid();
    logic s, a0, a1;
    logic [7:0] addr;
    addr = 8'h84;
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_cycle(addr[i], s);
    sda_m = 1'b1;
    @(negedge clk);
    checks++;
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL rstmid_ack_driven got=%b exp=1", sda_oe); end
    #3 rst_n = 1'b0;
    #1;
    checks += 4;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL rstmid_sda_oe got=%b exp=0", sda_oe); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rx_data got=%h exp=00", rx_data); end
    if (rw !== 1'b0) begin errors++; $display("FAIL rstmid_rw got=%b exp=0", rw); end
    tick(3);
    rst_n = 1'b1;
    tick(5);
    i2c_start();
    write_byte(8'h84, a0);
    write_byte(8'h3C, a1);
    i2c_stop();
    checks += 3;
    if (a0 !== 1'b0) begin errors++; $display("FAIL rstmid_after_addr_ack got=%b exp=0", a0); end
    if (a1 !== 1'b0) begin errors++; $display("FAIL rstmid_after_data_ack got=%b exp=0", a1); end
    if (rx_data !== 8'h3C) begin errors++; $display("FAIL rstmid_after_rx_data got=%h exp=3c", rx_data); end
  endtask
  task automatic test_glitch();
    logic s, ack, exp_ack;
    logic [7:0] addr;
    addr = 8'h84;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    exp_ack = 1'b0;
`else
    exp_ack = 1'b1;
`endif
    i2c_start();
    sda_m = addr[7]; tick(Q);
    scl_m = 1'b1; tick(10);
    scl_m = 1'b0; tick(2);
    scl_m = 1'b1; tick(Q - 12);
    tick(Q);
    scl_m = 1'b0; tick(Q);
    for (int i = 6; i >= 0; i--) bit_cycle(addr[i], s);
    bit_cycle(1'b1, ack);
    i2c_stop();
    checks++;
    if (ack !== exp_ack) begin errors++; $display("FAIL glitch_addr_ack got=%b exp=%b", ack, exp_ack); end
  endtask
  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_repeated_start();
    test_reset_mid();
    test_glitch();
    tick(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
